// File: rtl/alu_control_mc.sv
// Registered ALU control: decodes ALUOP/Funct into the ALU select code and holds it through multi-cycle MUL/DIV.
// Define ALU_CTRL_ILLEGAL_EN to flag undefined ops on 'illegal' instead of decoding them as code 0000.
module alu_control_mc #(
   parameter int SEL_W   = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 8,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [2:0]       ALUOP,
   input  logic [5:0]       Funct,
   input  logic             flush,
   output logic             ready,
   output logic [SEL_W-1:0] sel_out,
   output logic             sel_valid,
   output logic             alu_start,
   output logic             busy,
   output logic             illegal
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

`ifdef ALU_CTRL_ILLEGAL_EN
   localparam bit ILLEGAL_EN = 1'b1;
`else
   localparam bit ILLEGAL_EN = 1'b0;
`endif

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       code;
   logic             undef;
   logic             is_mul;
   logic             is_div;
   logic             trap;

   // Undefined ops fall out as code 0000 with undef set.
   always_comb begin
      code   = 4'b0000;
      undef  = 1'b0;
      is_mul = 1'b0;
      is_div = 1'b0;
      case (ALUOP)
         3'b000: code = 4'b0001;
         3'b001: code = 4'b0010;
         3'b011: code = 4'b0101;
         3'b100: code = 4'b1000;
         3'b101: code = 4'b0110;
         3'b010: begin
            case (Funct)
               6'b000000: code = 4'b0000;
               6'b100000: code = 4'b0001;
               6'b100010: code = 4'b0010;
               6'b000010: begin
                  code   = 4'b0011;
                  is_mul = 1'b1;
               end
               6'b011010: begin
                  code   = 4'b0100;
                  is_div = 1'b1;
               end
               6'b100100: code = 4'b0101;
               6'b100101: code = 4'b0110;
               6'b100111: code = 4'b0111;
               6'b100110: code = 4'b1001;
               6'b101010: code = 4'b1000;
               default:   undef = 1'b1;
            endcase
         end
         default: undef = 1'b1;
      endcase
   end

   assign trap  = ILLEGAL_EN & undef;
   assign ready = (state == IDLE);

   // Flush beats everything except reset; WAIT ignores valid_in until cnt reaches zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sel_out   <= '0;
         sel_valid <= 1'b0;
         alu_start <= 1'b0;
         busy      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         sel_valid <= 1'b0;
         alu_start <= 1'b0;
         illegal   <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
         end else if (state == IDLE) begin
            if (valid_in) begin
               if (trap) begin
                  illegal <= 1'b1;
                  sel_out <= '0;
               end else if (is_mul || is_div) begin
                  sel_out   <= SEL_W'(code);
                  alu_start <= 1'b1;
                  busy      <= 1'b1;
                  cnt       <= is_mul ? MUL_CNT : DIV_CNT;
                  state     <= WAIT;
               end else begin
                  sel_out   <= SEL_W'(code);
                  sel_valid <= 1'b1;
               end
            end
         end else begin
            if (cnt == '0) begin
               state     <= IDLE;
               busy      <= 1'b0;
               sel_valid <= 1'b1;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_control_mc.sv
// Bench for alu_control_mc: directed vector table, a full-latency DIV sequence, then random traffic against a reference model.
module tb_alu_control_mc;

   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 8;

`ifdef ALU_CTRL_ILLEGAL_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic       flush;
      logic [2:0] aluop;
      logic [5:0] funct;
   } stim_t;

   typedef struct packed {
      logic       ready;
      logic [3:0] sel;
      logic       sel_valid;
      logic       alu_start;
      logic       busy;
      logic       illegal;
   } resp_t;

   typedef struct packed {
      stim_t s;
      resp_t r;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_in;
   logic       flush;
   logic [2:0] ALUOP;
   logic [5:0] Funct;
   logic       ready;
   logic [3:0] sel_out;
   logic       sel_valid;
   logic       alu_start;
   logic       busy;
   logic       illegal;

   int vectors = 0;
   int miscompares = 0;

   int rtype[int];
   int itype[int];

   int m_sel;
   int m_rem;
   bit m_sv;
   bit m_st;
   bit m_ill;

   vec_t tbl[$];

   always #5 clk = ~clk;

   alu_control_mc #(
      .SEL_W(4),
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .valid_in(valid_in),
      .ALUOP(ALUOP),
      .Funct(Funct),
      .flush(flush),
      .ready(ready),
      .sel_out(sel_out),
      .sel_valid(sel_valid),
      .alu_start(alu_start),
      .busy(busy),
      .illegal(illegal)
   );

   function automatic stim_t mkStim(bit r, bit v, bit f, logic [2:0] a, logic [5:0] fn);
      stim_t s;
      s.rst   = r;
      s.valid = v;
      s.flush = f;
      s.aluop = a;
      s.funct = fn;
      return s;
   endfunction

   function automatic resp_t mkResp(bit rd, logic [3:0] sel, bit sv, bit st, bit bz, bit il);
      resp_t r;
      r.ready     = rd;
      r.sel       = sel;
      r.sel_valid = sv;
      r.alu_start = st;
      r.busy      = bz;
      r.illegal   = il;
      return r;
   endfunction

   function automatic vec_t mk(bit r, bit v, bit f, logic [2:0] a, logic [5:0] fn,
                               bit rd, logic [3:0] sel, bit sv, bit st, bit bz, bit il);
      vec_t x;
      x.s = mkStim(r, v, f, a, fn);
      x.r = mkResp(rd, sel, sv, st, bz, il);
      return x;
   endfunction

   // Reference decode straight from the opcode tables.
   task automatic refDecode(input logic [2:0] a, input logic [5:0] fn, output int code, output bit known);
      code  = 0;
      known = 1'b0;
      if (a == 3'b010) begin
         if (rtype.exists(int'(fn))) begin
            code  = rtype[int'(fn)];
            known = 1'b1;
         end
      end else if (itype.exists(int'(a))) begin
         code  = itype[int'(a)];
         known = 1'b1;
      end
   endtask

   function automatic int refLatency(logic [2:0] a, logic [5:0] fn);
      if (a == 3'b010 && fn == 6'b000010) return MUL_LAT;
      if (a == 3'b010 && fn == 6'b011010) return DIV_LAT;
      return 0;
   endfunction

   // Model tracks the number of busy cycles still to run rather than a down-counter.
   task automatic modelEdge(input stim_t s);
      int  code;
      bit  known;
      int  lat;
      m_sv  = 1'b0;
      m_st  = 1'b0;
      m_ill = 1'b0;
      if (s.rst) begin
         m_sel = 0;
         m_rem = 0;
      end else if (s.flush) begin
         m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) m_sv = 1'b1;
      end else if (s.valid) begin
         refDecode(s.aluop, s.funct, code, known);
         lat = refLatency(s.aluop, s.funct);
         if (!known && ILL_EN) begin
            m_ill = 1'b1;
            m_sel = 0;
         end else if (lat > 0) begin
            m_sel = code;
            m_rem = lat;
            m_st  = 1'b1;
         end else begin
            m_sel = code;
            m_sv  = 1'b1;
         end
      end
   endtask

   function automatic resp_t modelResp();
      return mkResp(m_rem == 0, 4'(m_sel), m_sv, m_st, m_rem > 0, m_ill);
   endfunction

   task automatic applyStimulus(input stim_t s);
      rst      = s.rst;
      valid_in = s.valid;
      flush    = s.flush;
      ALUOP    = s.aluop;
      Funct    = s.funct;
      @(posedge clk);
      modelEdge(s);
      #1;
   endtask

   task automatic checkOutput(input string name, input resp_t exp);
      resp_t act;
      act = mkResp(ready, sel_out, sel_valid, alu_start, busy, illegal);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got rdy=%b sel=%h sv=%b st=%b busy=%b ill=%b, expected rdy=%b sel=%h sv=%b st=%b busy=%b ill=%b",
                  name, act.ready, act.sel, act.sel_valid, act.alu_start, act.busy, act.illegal,
                  exp.ready, exp.sel, exp.sel_valid, exp.alu_start, exp.busy, exp.illegal);
      end
   endtask

   initial begin
      stim_t s;
      stim_t idle;
      int    busyCycles;
      bit    gotValid;
      logic [5:0] functs[10];

      rtype[6'b000000] = 0; rtype[6'b100000] = 1; rtype[6'b100010] = 2;
      rtype[6'b000010] = 3; rtype[6'b011010] = 4; rtype[6'b100100] = 5;
      rtype[6'b100101] = 6; rtype[6'b100111] = 7; rtype[6'b100110] = 9;
      rtype[6'b101010] = 8;
      itype[0] = 1; itype[1] = 2; itype[3] = 5; itype[4] = 8; itype[5] = 6;
      functs = '{6'b000000, 6'b100000, 6'b100010, 6'b000010, 6'b011010,
                 6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b101010};
      m_sel = 0; m_rem = 0; m_sv = 0; m_st = 0; m_ill = 0;

      rst = 1'b1; valid_in = 1'b0; flush = 1'b0; ALUOP = '0; Funct = '0;
      idle = mkStim(0, 0, 0, 3'b000, 6'b000000);

      //           rst v f aluop   funct      rdy sel     sv st bz il
      tbl.push_back(mk(1, 0, 0, 3'b000, 6'b000000, 1, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 3'b000, 6'b000000, 1, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 1, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b010, 6'b100010, 1, 4'h2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b000, 6'b000000, 1, 4'h1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b011, 6'b000000, 1, 4'h5, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b101, 6'b000000, 1, 4'h6, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 1, 4'h6, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b010, 6'b000010, 0, 4'h3, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 0, 3'b000, 6'b000000, 0, 4'h3, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 0, 4'h3, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 0, 4'h3, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 1, 4'h3, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b010, 6'b011010, 0, 4'h4, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 0, 4'h4, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 0, 4'h4, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 3'b000, 6'b000000, 1, 4'h4, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b000, 6'b000000, 1, 4'h1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b010, 6'b011010, 0, 4'h4, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 3'b000, 6'b000000, 0, 4'h4, 0, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 3'b000, 6'b000000, 1, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 3'b000, 6'b000000, 1, 4'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b100, 6'b000000, 1, 4'h8, 1, 0, 0, 0));
      if (ILL_EN) begin
         tbl.push_back(mk(0, 1, 0, 3'b010, 6'b111111, 1, 4'h0, 0, 0, 0, 1));
         tbl.push_back(mk(0, 1, 0, 3'b010, 6'b101010, 1, 4'h8, 1, 0, 0, 0));
         tbl.push_back(mk(0, 1, 0, 3'b110, 6'b000000, 1, 4'h0, 0, 0, 0, 1));
      end else begin
         tbl.push_back(mk(0, 1, 0, 3'b010, 6'b111111, 1, 4'h0, 1, 0, 0, 0));
         tbl.push_back(mk(0, 1, 0, 3'b010, 6'b101010, 1, 4'h8, 1, 0, 0, 0));
         tbl.push_back(mk(0, 1, 0, 3'b110, 6'b000000, 1, 4'h0, 1, 0, 0, 0));
      end
      tbl.push_back(mk(0, 1, 0, 3'b001, 6'b000000, 1, 4'h2, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 3'b010, 6'b100110, 1, 4'h9, 1, 0, 0, 0));

      foreach (tbl[i]) begin
         applyStimulus(tbl[i].s);
         checkOutput($sformatf("tbl[%0d]", i), tbl[i].r);
      end

      // Full DIV run: count busy cycles until the completion pulse, bounded.
      busyCycles = 0;
      gotValid   = 1'b0;
      applyStimulus(mkStim(0, 1, 0, 3'b010, 6'b011010));
      for (int i = 0; i < 20 && !gotValid; i++) begin
         if (busy) busyCycles++;
         if (sel_valid) gotValid = 1'b1;
         if (!gotValid) applyStimulus(idle);
      end
      vectors++;
      if (!(gotValid && busyCycles == DIV_LAT && sel_out == 4'h4)) begin
         miscompares++;
         $display("[TB] FAIL div_latency: got busy_cycles=%0d done=%b sel=%h, expected busy_cycles=%0d done=1 sel=4",
                  busyCycles, gotValid, sel_out, DIV_LAT);
      end

      for (int i = 0; i < 600; i++) begin
         s.rst   = ($urandom_range(0, 63) == 0);
         s.flush = ($urandom_range(0, 15) == 0);
         s.valid = $urandom_range(0, 1) == 1;
         s.aluop = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) s.funct = functs[$urandom_range(0, 9)];
         else s.funct = 6'($urandom);
         applyStimulus(s);
         checkOutput($sformatf("rand[%0d]", i), modelResp());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
